// File: rtl/fan_pkg.sv
// Shared definitions for the fan speed controller: speed encodings, timer
// select width and the duty-percent to clock-cycles conversion.
package fan_pkg;

   typedef enum logic [1:0] {
      SPD_OFF  = 2'd0,
      SPD_LOW  = 2'd1,
      SPD_MID  = 2'd2,
      SPD_HIGH = 2'd3
   } spd_e;

   localparam int TSEL_W = 2;

   function automatic int duty_cycles(input int period, input int pct);
      return (period * pct) / 100;
   endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Free-running PWM generator with a duty register that reloads only at the
// period boundary. Optional spin-up kick guarded by FAN_KICK_START_EN.
module fan_pwm_gen
   import fan_pkg::*;
#(
   parameter int PWM_PERIOD   = 1000,
   parameter int KICK_PERIODS = 50,
   localparam int DUTY_W      = $clog2(PWM_PERIOD + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] level_duty_i,
   input  logic              kick_req_i,
   output logic              pwm_o
);

   localparam int                CNT_W     = $clog2(PWM_PERIOD);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_PERIOD - 1);
   localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(PWM_PERIOD);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              boundary;

   assign boundary = (cnt_q == CNT_LAST);
   assign cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);
   assign pwm_o    = (DUTY_W'(cnt_q) < duty_q);

`ifdef FAN_KICK_START_EN
   // KICK_PERIODS is expected to be at least 1 when the kick is built in.
   localparam int KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;

   logic          kick_pend_q, kick_pend_d;
   logic [KW-1:0] kick_left_q, kick_left_d;

   always_comb begin
      duty_d      = duty_q;
      kick_pend_d = kick_pend_q;
      kick_left_d = kick_left_q;
      if (boundary) begin
         if (level_duty_i == '0) begin
            duty_d      = '0;
            kick_pend_d = 1'b0;
            kick_left_d = '0;
         end else if (kick_pend_q) begin
            duty_d      = DUTY_FULL;
            kick_pend_d = 1'b0;
            kick_left_d = KW'(KICK_PERIODS - 1);
         end else if (kick_left_q != '0) begin
            duty_d      = DUTY_FULL;
            kick_left_d = kick_left_q - KW'(1);
         end else begin
            duty_d = level_duty_i;
         end
      end
      // A spin-up request on a boundary edge must survive that edge's reload.
      if (kick_req_i) kick_pend_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kick_pend_q <= 1'b0;
         kick_left_q <= '0;
      end else begin
         kick_pend_q <= kick_pend_d;
         kick_left_q <= kick_left_d;
      end
   end
`else
   logic unused_kick;
   assign unused_kick = kick_req_i | (KICK_PERIODS == 0) | (DUTY_FULL == '0);

   always_comb begin
      duty_d = duty_q;
      if (boundary) duty_d = level_duty_i;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         duty_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
      end
   end

endmodule

// File: rtl/fan_speed_ctrl.sv
// Fan speed FSM and auto-off timer driven by button gesture pulses; the PWM
// stage lives in fan_pwm_gen. Optional spin-up kick: FAN_KICK_START_EN.
module fan_speed_ctrl
   import fan_pkg::*;
#(
   parameter int CLK_PER_SEC    = 125_000_000,
   parameter int PWM_PERIOD     = 1000,
   parameter int DUTY_LOW       = 30,
   parameter int DUTY_MID       = 60,
   parameter int DUTY_HIGH      = 100,
   parameter int TIMER_STEP_SEC = 3600,
   parameter int KICK_PERIODS   = 50
) (
   input  logic              clk,
   input  logic              reset_p,
   input  logic              single,
   input  logic              double,
   input  logic              long,
   output logic              pwm_out,
   output logic [1:0]        speed_level,
   output logic [TSEL_W-1:0] timer_sel,
   output logic [15:0]       remaining_sec,
   output logic              timer_expired
);

   localparam int                DUTY_W     = $clog2(PWM_PERIOD + 1);
   localparam int                PW         = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_PER_SEC - 1);
   localparam logic [DUTY_W-1:0] DUTY_LOW_C  = DUTY_W'(duty_cycles(PWM_PERIOD, DUTY_LOW));
   localparam logic [DUTY_W-1:0] DUTY_MID_C  = DUTY_W'(duty_cycles(PWM_PERIOD, DUTY_MID));
   localparam logic [DUTY_W-1:0] DUTY_HIGH_C = DUTY_W'(duty_cycles(PWM_PERIOD, DUTY_HIGH));

   spd_e              spd_q, spd_d, spd_next;
   logic [TSEL_W-1:0] tsel_q, tsel_d, tsel_inc;
   logic [15:0]       rem_q, rem_d, rem_load;
   logic [PW-1:0]     presc_q, presc_d;
   logic              exp_q, exp_d;
   logic              expire;
   logic              kick_req;
   logic [DUTY_W-1:0] level_duty;

   assign expire   = (tsel_q != '0) && (rem_q == '0);
   assign tsel_inc = tsel_q + TSEL_W'(1);
   assign rem_load = 16'(int'(tsel_inc) * TIMER_STEP_SEC);

   always_comb begin
      case (spd_q)
         SPD_OFF: spd_next = SPD_LOW;
         SPD_LOW: spd_next = SPD_MID;
         SPD_MID: spd_next = SPD_HIGH;
         default: spd_next = SPD_OFF;
      endcase
   end

   // Expiry outranks every user pulse; among pulses long > single > double.
   always_comb begin
      spd_d   = spd_q;
      tsel_d  = tsel_q;
      rem_d   = rem_q;
      presc_d = presc_q;
      exp_d   = 1'b0;
      if (expire || long || (single && spd_q == SPD_HIGH)) begin
         spd_d   = SPD_OFF;
         tsel_d  = '0;
         rem_d   = '0;
         presc_d = '0;
         exp_d   = expire;
      end else if (double && !single && spd_q != SPD_OFF) begin
         tsel_d  = tsel_inc;
         rem_d   = rem_load;
         presc_d = '0;
      end else begin
         if (single) spd_d = spd_next;
         if (tsel_q != '0) begin
            if (presc_q == PRESC_LAST) begin
               presc_d = '0;
               rem_d   = rem_q - 16'd1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         spd_q   <= SPD_OFF;
         tsel_q  <= '0;
         rem_q   <= '0;
         presc_q <= '0;
         exp_q   <= 1'b0;
      end else begin
         spd_q   <= spd_d;
         tsel_q  <= tsel_d;
         rem_q   <= rem_d;
         presc_q <= presc_d;
         exp_q   <= exp_d;
      end
   end

   always_comb begin
      case (spd_q)
         SPD_LOW:  level_duty = DUTY_LOW_C;
         SPD_MID:  level_duty = DUTY_MID_C;
         SPD_HIGH: level_duty = DUTY_HIGH_C;
         default:  level_duty = '0;
      endcase
   end

   assign kick_req = (spd_q == SPD_OFF) && (spd_d != SPD_OFF);

   fan_pwm_gen #(
      .PWM_PERIOD   (PWM_PERIOD),
      .KICK_PERIODS (KICK_PERIODS)
   ) u_pwm (
      .clk          (clk),
      .rst          (reset_p),
      .level_duty_i (level_duty),
      .kick_req_i   (kick_req),
      .pwm_o        (pwm_out)
   );

   assign speed_level   = spd_q;
   assign timer_sel     = tsel_q;
   assign remaining_sec = rem_q;
   assign timer_expired = exp_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed bench for fan_speed_ctrl with small timing constants; expected
// values are hand-derived from the behaviour description.
module tb_fan_speed_ctrl;

   localparam int CLK_PER_SEC    = 10;
   localparam int PWM_PERIOD     = 100;
   localparam int TIMER_STEP_SEC = 3;
   localparam int KICK_PERIODS   = 2;
`ifdef FAN_KICK_START_EN
   localparam int KICK_EXTRA = 2;
`else
   localparam int KICK_EXTRA = 0;
`endif

   logic        clk     = 1'b0;
   logic        reset_p = 1'b1;
   logic        single  = 1'b0;
   logic        double  = 1'b0;
   logic        long    = 1'b0;
   logic        pwm_out;
   logic [1:0]  speed_level;
   logic [1:0]  timer_sel;
   logic [15:0] remaining_sec;
   logic        timer_expired;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   // Cycles since reset release; cyc % PWM_PERIOD mirrors the expected PWM phase.
   always @(posedge clk or posedge reset_p) begin
      if (reset_p) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   fan_speed_ctrl #(
      .CLK_PER_SEC    (CLK_PER_SEC),
      .PWM_PERIOD     (PWM_PERIOD),
      .DUTY_LOW       (30),
      .DUTY_MID       (60),
      .DUTY_HIGH      (100),
      .TIMER_STEP_SEC (TIMER_STEP_SEC),
      .KICK_PERIODS   (KICK_PERIODS)
   ) dut (
      .clk           (clk),
      .reset_p       (reset_p),
      .single        (single),
      .double        (double),
      .long          (long),
      .pwm_out       (pwm_out),
      .speed_level   (speed_level),
      .timer_sel     (timer_sel),
      .remaining_sec (remaining_sec),
      .timer_expired (timer_expired)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic s, input logic d, input logic l);
      @(negedge clk);
      single = s;
      double = d;
      long   = l;
      @(negedge clk);
      single = 1'b0;
      double = 1'b0;
      long   = 1'b0;
   endtask

   task automatic wait_boundary();
      int n;
      n = 0;
      @(negedge clk);
      while ((cyc % PWM_PERIOD) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("boundary_wait", (n < 200), 1);
   endtask

   task automatic measure(input string tag, input int exp_high);
      int hi;
      hi = 0;
      wait_boundary();
      for (int i = 0; i < PWM_PERIOD; i++) begin
         if (pwm_out === 1'b1) hi++;
         if (i < PWM_PERIOD - 1) @(negedge clk);
      end
      check(tag, hi, exp_high);
   endtask

   initial begin
      int mism;
      int n;
      int n_exp;
      int exp_k;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_speed", speed_level, 0);
      check("rst_tsel", timer_sel, 0);
      check("rst_rem", remaining_sec, 0);
      check("rst_expired", timer_expired, 0);
      check("rst_pwm", pwm_out, 0);
      reset_p = 1'b0;

      // Single cycling through the levels
      pulse(1, 0, 0);
      check("single1_speed", speed_level, 1);
`ifdef FAN_KICK_START_EN
      measure("kick_period1", 100);
      measure("kick_period2", 100);
`endif
      measure("low_high_time", 30);
      pulse(1, 0, 0);
      check("single2_speed", speed_level, 2);
      measure("mid_high_time", 60);
      pulse(1, 0, 0);
      check("single3_speed", speed_level, 3);
      measure("high_high_time", 100);
      pulse(1, 0, 0);
      check("single4_speed", speed_level, 0);
      measure("off_high_time", 0);

      // Long at MID mid-period: current period completes untouched
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      check("mid_again_speed", speed_level, 2);
      for (int i = 0; i <= KICK_EXTRA; i++) wait_boundary();
      repeat (20) @(negedge clk);
      pulse(0, 0, 1);
      check("long_speed", speed_level, 0);
      mism = 0;
      n = 0;
      while ((cyc % PWM_PERIOD) != 0 && n < 200) begin
         if (pwm_out !== ((cyc % PWM_PERIOD) < 60)) mism++;
         @(negedge clk);
         n++;
      end
      check("long_tail_mism", mism, 0);
      check("long_boundary_pwm", pwm_out, 0);
      measure("long_next_period", 0);

      // Off-timer expiry at LOW
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      check("timer_low_tsel", timer_sel, 1);
      check("timer_low_rem", remaining_sec, 3);
      n_exp = 0;
      exp_k = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 9)  check("rem_k9", remaining_sec, 3);
         if (k == 10) check("rem_k10", remaining_sec, 2);
         if (k == 30) begin
            check("rem_k30", remaining_sec, 0);
            check("speed_k30", speed_level, 1);
         end
         if (timer_expired === 1'b1) begin
            n_exp++;
            if (exp_k == 0) exp_k = k;
         end
      end
      check("expire_count", n_exp, 1);
      check("expire_cycle", exp_k, 31);
      check("expire_speed", speed_level, 0);
      check("expire_tsel", timer_sel, 0);

      // Timer select cycling at HIGH
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      check("high_speed", speed_level, 3);
      pulse(0, 1, 0);
      check("dbl1_tsel", timer_sel, 1);
      check("dbl1_rem", remaining_sec, 3);
      pulse(0, 1, 0);
      check("dbl2_tsel", timer_sel, 2);
      check("dbl2_rem", remaining_sec, 6);
      pulse(0, 1, 0);
      check("dbl3_tsel", timer_sel, 3);
      check("dbl3_rem", remaining_sec, 9);
      pulse(0, 1, 0);
      check("dbl4_tsel", timer_sel, 0);
      check("dbl4_rem", remaining_sec, 0);
      check("dbl4_speed", speed_level, 3);
      pulse(0, 1, 0);
      pulse(0, 0, 1);
      check("high_long_speed", speed_level, 0);
      check("high_long_tsel", timer_sel, 0);
      pulse(0, 1, 0);
      check("dbl_off_tsel", timer_sel, 0);
      check("dbl_off_rem", remaining_sec, 0);

      // Coincident pulses
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      pulse(1, 0, 1);
      check("single_long_speed", speed_level, 0);
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      check("pre_combo_rem", remaining_sec, 3);
      pulse(1, 1, 0);
      check("dbl_single_speed", speed_level, 2);
      check("dbl_single_tsel", timer_sel, 1);
      check("dbl_single_rem", remaining_sec, 3);
      pulse(0, 0, 1);
      check("combo_long_rem", remaining_sec, 0);

      // Asynchronous reset mid-period at HIGH with a timer running
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      wait_boundary();
      repeat (10) @(negedge clk);
      check("pre_reset_pwm", pwm_out, 1);
      #2;
      reset_p = 1'b1;
      #1;
      check("async_rst_pwm", pwm_out, 0);
      check("async_rst_speed", speed_level, 0);
      check("async_rst_tsel", timer_sel, 0);
      check("async_rst_rem", remaining_sec, 0);
      @(negedge clk);
      reset_p = 1'b0;
      pulse(1, 0, 0);
      for (int i = 0; i < KICK_EXTRA; i++) wait_boundary();
      measure("post_reset_low", 30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
